// File: rtl/axis_pkg.sv
// Shared helpers for the AXI4-Stream width converters: index sizing and
// derived wide-side widths.
package axis_pkg;

    // Widest lane index any converter in this slice is expected to need.
    localparam int LANE_SEL_MAX_W = 8;

    // Lane selector type, wide enough for any supported RATIO.
    typedef logic [LANE_SEL_MAX_W-1:0] lane_sel_t;

    // Bits needed to count 0..n-1, never less than one bit so RATIO=1 still
    // gets a real (constant-zero) index register.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a field after concatenating `ratio` narrow lanes.
    function automatic int wide_w(input int narrowW, input int ratio);
        return narrowW * ratio;
    endfunction

    // Byte-enable width that goes with a tdata width.
    function automatic int keep_w(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Generic AXI4-Stream bundle with Master/Slave views.
interface axi4_stream_if #(
    parameter int TDATA_W = 32,
    parameter int TUSER_W = 1,
    parameter int TID_W   = 1,
    parameter int TDEST_W = 1
);
    localparam int TKEEP_W = TDATA_W / 8;

    logic               tvalid;
    logic               tready;
    logic [TDATA_W-1:0] tdata;
    logic [TKEEP_W-1:0] tstrb;
    logic [TKEEP_W-1:0] tkeep;
    logic               tlast;
    logic [TID_W-1:0]   tid;
    logic [TDEST_W-1:0] tdest;
    logic [TUSER_W-1:0] tuser;

    modport Master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport Slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/axis_upsizer.sv
// Packs RATIO consecutive narrow AXI4-Stream beats into one wide beat.
// The packing register drives the master side directly, so the output is
// fully registered; a new wide beat can start in the same cycle the previous
// one drains, which keeps the input running at one beat per cycle.
module axis_upsizer
    import axis_pkg::*;
#(
    parameter int TDATA_IN_W = 32,
    parameter int RATIO      = 4,
    parameter int TID_W      = 1,
    parameter int TDEST_W    = 1,
    parameter int TUSER_IN_W = 1
) (
    input logic           clk,
    input logic           rst_n,
    axi4_stream_if.Slave  s_axis,
    axi4_stream_if.Master m_axis
);

    localparam int KEEP_IN_W  = keep_w(TDATA_IN_W);
    localparam int DATA_OUT_W = wide_w(TDATA_IN_W, RATIO);
    localparam int KEEP_OUT_W = wide_w(KEEP_IN_W, RATIO);
    localparam int USER_OUT_W = wide_w(TUSER_IN_W, RATIO);
    localparam int IDX_W      = clog2_min1(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Parameter sanity and interface width agreement are checked at elaboration.
    if (RATIO < 1 || (TDATA_IN_W % 8) != 0 || IDX_W > LANE_SEL_MAX_W) begin : gParamCheck
        $fatal(1, "axis_upsizer: illegal RATIO or TDATA_IN_W");
    end
    if ($bits(s_axis.tdata) != TDATA_IN_W || $bits(s_axis.tuser) != TUSER_IN_W ||
        $bits(s_axis.tid) != TID_W || $bits(s_axis.tdest) != TDEST_W) begin : gSlaveCheck
        $fatal(1, "axis_upsizer: s_axis widths do not match parameters");
    end
    if ($bits(m_axis.tdata) != DATA_OUT_W || $bits(m_axis.tuser) != USER_OUT_W ||
        $bits(m_axis.tid) != TID_W || $bits(m_axis.tdest) != TDEST_W) begin : gMasterCheck
        $fatal(1, "axis_upsizer: m_axis widths do not match parameters");
    end

    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [DATA_OUT_W-1:0] data_q,   data_d;
    logic [KEEP_OUT_W-1:0] strb_q,   strb_d;
    logic [KEEP_OUT_W-1:0] keep_q,   keep_d;
    logic [USER_OUT_W-1:0] user_q,   user_d;
    logic [TID_W-1:0]      tid_q,    tid_d;
    logic [TDEST_W-1:0]    tdest_q,  tdest_d;
    logic                  mValid_q, mValid_d;
    logic                  mLast_q,  mLast_d;

    logic idMismatch;
    logic closeId;
    logic sReady;
    logic accept;
    logic drain;

    // A stream-id change mid-beat flushes the partial beat before the new id
    // is consumed; only checked while the output slot is free.
    always_comb begin
        idMismatch = (s_axis.tid != tid_q) || (s_axis.tdest != tdest_q);
        closeId    = (idx_q != '0) && s_axis.tvalid && !mValid_q && idMismatch;
        sReady     = (!mValid_q || m_axis.tready) && !closeId;
        accept     = s_axis.tvalid && sReady;
        drain      = mValid_q && m_axis.tready;
    end

    // Next-state for the packing register, lane index and output flags.
    always_comb begin
        idx_d    = idx_q;
        data_d   = data_q;
        strb_d   = strb_q;
        keep_d   = keep_q;
        user_d   = user_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        mValid_d = mValid_q;
        mLast_d  = mLast_q;

        if (drain) begin
            mValid_d = 1'b0;
        end

        if (closeId) begin
            mValid_d = 1'b1;
            mLast_d  = 1'b0;
            idx_d    = '0;
        end else if (accept) begin
            if (idx_q == '0) begin
                data_d  = '0;
                strb_d  = '0;
                keep_d  = '0;
                user_d  = '0;
                tid_d   = s_axis.tid;
                tdest_d = s_axis.tdest;
            end
            data_d[int'(idx_q)*TDATA_IN_W +: TDATA_IN_W] = s_axis.tdata;
            strb_d[int'(idx_q)*KEEP_IN_W  +: KEEP_IN_W]  = s_axis.tstrb;
            keep_d[int'(idx_q)*KEEP_IN_W  +: KEEP_IN_W]  = s_axis.tkeep;
            user_d[int'(idx_q)*TUSER_IN_W +: TUSER_IN_W] = s_axis.tuser;
            if (idx_q == LAST_IDX || s_axis.tlast) begin
                mValid_d = 1'b1;
                mLast_d  = s_axis.tlast;
                idx_d    = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // State register; reset discards any partially packed beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            keep_q   <= '0;
            user_q   <= '0;
            tid_q    <= '0;
            tdest_q  <= '0;
            mValid_q <= 1'b0;
            mLast_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            keep_q   <= keep_d;
            user_q   <= user_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
            mValid_q <= mValid_d;
            mLast_q  <= mLast_d;
        end
    end

    assign s_axis.tready = sReady;
    assign m_axis.tvalid = mValid_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tstrb  = strb_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tuser  = user_q;
    assign m_axis.tlast  = mLast_q;
    assign m_axis.tid    = tid_q;
    assign m_axis.tdest  = tdest_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// Bench for axis_upsizer: a RATIO=4 instance driven from a vector table plus
// hand-written stall/reset sequences, and a RATIO=1 instance under random
// valid/ready traffic.
module tb_axis_upsizer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_W(32),  .TUSER_W(1), .TID_W(2), .TDEST_W(1)) sIf ();
    axi4_stream_if #(.TDATA_W(128), .TUSER_W(4), .TID_W(2), .TDEST_W(1)) mIf ();
    axi4_stream_if #(.TDATA_W(32),  .TUSER_W(1), .TID_W(2), .TDEST_W(1)) s1If ();
    axi4_stream_if #(.TDATA_W(32),  .TUSER_W(1), .TID_W(2), .TDEST_W(1)) m1If ();

    axis_upsizer #(
        .TDATA_IN_W (32),
        .RATIO      (4),
        .TID_W      (2),
        .TDEST_W    (1),
        .TUSER_IN_W (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axis (sIf.Slave),
        .m_axis (mIf.Master)
    );

    axis_upsizer #(
        .TDATA_IN_W (32),
        .RATIO      (1),
        .TID_W      (2),
        .TDEST_W    (1),
        .TUSER_IN_W (1)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_axis (s1If.Slave),
        .m_axis (m1If.Master)
    );

    typedef struct {
        logic         sValid;
        logic [31:0]  sData;
        logic [3:0]   sKeep;
        logic         sUser;
        logic         sLast;
        logic [1:0]   sId;
        logic         sDest;
        logic         mReady;
        logic         expSReady;
        logic         expMValid;
        logic [127:0] expData;
        logic [15:0]  expKeep;
        logic [3:0]   expUser;
        logic         expLast;
        logic [1:0]   expId;
        logic         expDest;
    } vec_t;

    localparam int MAIN_VECS = 20;

    vec_t vecs[$];
    int   checkCount = 0;
    int   passCount  = 0;

    // Stall-sequence bookkeeping.
    logic [127:0] expWide [2];
    logic [127:0] heldData;
    int           ptr;
    int           outCnt;
    int           stallLeft;
    logic         accepted;
    logic         stalled;

    // Random RATIO=1 bookkeeping.
    logic [36:0]  sbQueue[$];
    logic [36:0]  curBeat;
    logic [36:0]  expBeat;
    logic         pending;
    logic         acc1;
    int           sent;
    int           got;

    function automatic vec_t mkVec(
        input logic sValid, input logic [31:0] sData, input logic [3:0] sKeep,
        input logic sUser, input logic sLast, input logic [1:0] sId, input logic sDest,
        input logic mReady, input logic expSReady, input logic expMValid,
        input logic [127:0] expData, input logic [15:0] expKeep, input logic [3:0] expUser,
        input logic expLast, input logic [1:0] expId, input logic expDest);
        vec_t v;
        v.sValid    = sValid;    v.sData   = sData;   v.sKeep   = sKeep;
        v.sUser     = sUser;     v.sLast   = sLast;   v.sId     = sId;
        v.sDest     = sDest;     v.mReady  = mReady;  v.expSReady = expSReady;
        v.expMValid = expMValid; v.expData = expData; v.expKeep = expKeep;
        v.expUser   = expUser;   v.expLast = expLast; v.expId   = expId;
        v.expDest   = expDest;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        sIf.tvalid  = v.sValid;
        sIf.tdata   = v.sData;
        sIf.tkeep   = v.sKeep;
        sIf.tstrb   = v.sKeep;
        sIf.tuser   = v.sUser;
        sIf.tlast   = v.sLast;
        sIf.tid     = v.sId;
        sIf.tdest   = v.sDest;
        mIf.tready  = v.mReady;
    endtask

    task automatic runVector(input int i);
        vec_t v;
        v = vecs[i];
        applyStimulus(v);
        #1;
        checkOutput($sformatf("v%0d s_tready", i), 128'(sIf.tready), 128'(v.expSReady));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d m_tvalid", i), 128'(mIf.tvalid), 128'(v.expMValid));
        if (v.expMValid) begin
            checkOutput($sformatf("v%0d m_tdata", i), mIf.tdata, v.expData);
            checkOutput($sformatf("v%0d m_tkeep", i), 128'(mIf.tkeep), 128'(v.expKeep));
            checkOutput($sformatf("v%0d m_tstrb", i), 128'(mIf.tstrb), 128'(v.expKeep));
            checkOutput($sformatf("v%0d m_tuser", i), 128'(mIf.tuser), 128'(v.expUser));
            checkOutput($sformatf("v%0d m_tlast", i), 128'(mIf.tlast), 128'(v.expLast));
            checkOutput($sformatf("v%0d m_tid", i),   128'(mIf.tid),   128'(v.expId));
            checkOutput($sformatf("v%0d m_tdest", i), 128'(mIf.tdest), 128'(v.expDest));
        end
    endtask

    // Hard stop in case a bounded loop is somehow bypassed.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Main table: full packet, short packet, id change, stall, dest change, partial beat.
        vecs.push_back(mkVec(1, 32'h11111111, 4'hF, 1, 0, 2'd1, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h22222222, 4'hF, 0, 0, 2'd1, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h33333333, 4'hF, 1, 0, 2'd1, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h44444444, 4'hF, 1, 1, 2'd1, 0, 1, 1, 1,
                             128'h44444444_33333333_22222222_11111111, 16'hFFFF, 4'hD, 1, 2'd1, 0));
        vecs.push_back(mkVec(1, 32'h0000000A, 4'hF, 1, 0, 2'd1, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h0000000B, 4'hF, 1, 1, 2'd1, 0, 1, 1, 1,
                             128'h0000000B_0000000A, 16'h00FF, 4'h3, 1, 2'd1, 0));
        vecs.push_back(mkVec(1, 32'h000000C0, 4'hF, 0, 0, 2'd1, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000C1, 4'hF, 0, 0, 2'd1, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000D0, 4'hF, 0, 0, 2'd2, 0, 1, 0, 1,
                             128'h000000C1_000000C0, 16'h00FF, 4'h0, 0, 2'd1, 0));
        vecs.push_back(mkVec(1, 32'h000000D0, 4'hF, 0, 0, 2'd2, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000D1, 4'hF, 0, 1, 2'd2, 0, 1, 1, 1,
                             128'h000000D1_000000D0, 16'h00FF, 4'h0, 1, 2'd2, 0));
        vecs.push_back(mkVec(1, 32'h000000E0, 4'hF, 0, 0, 2'd0, 1, 0, 0, 1,
                             128'h000000D1_000000D0, 16'h00FF, 4'h0, 1, 2'd2, 0));
        vecs.push_back(mkVec(1, 32'h000000E0, 4'hF, 0, 0, 2'd0, 1, 0, 0, 1,
                             128'h000000D1_000000D0, 16'h00FF, 4'h0, 1, 2'd2, 0));
        vecs.push_back(mkVec(1, 32'h000000E0, 4'hF, 0, 0, 2'd0, 1, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000E1, 4'hF, 0, 1, 2'd0, 1, 1, 1, 1,
                             128'h000000E1_000000E0, 16'h00FF, 4'h0, 1, 2'd0, 1));
        vecs.push_back(mkVec(0, 32'h00000000, 4'h0, 0, 0, 2'd0, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000F0, 4'hF, 0, 0, 2'd0, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000F1, 4'hF, 0, 0, 2'd0, 1, 1, 0, 1,
                             128'h000000F0, 16'h000F, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000F1, 4'hF, 0, 0, 2'd0, 1, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000F2, 4'hF, 0, 0, 2'd0, 1, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        // After the mid-packet reset: clean 4-lane beat with an empty lane 1.
        vecs.push_back(mkVec(1, 32'h000000A0, 4'hF, 0, 0, 2'd3, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000A1, 4'h0, 0, 0, 2'd3, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000A2, 4'hF, 0, 0, 2'd3, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));
        vecs.push_back(mkVec(1, 32'h000000A3, 4'hF, 0, 1, 2'd3, 0, 1, 1, 1,
                             128'h000000A3_000000A2_000000A1_000000A0, 16'hFF0F, 4'h0, 1, 2'd3, 0));
        vecs.push_back(mkVec(0, 32'h00000000, 4'h0, 0, 0, 2'd0, 0, 1, 1, 0, 128'h0, 16'h0, 4'h0, 0, 2'd0, 0));

        expWide[0] = 128'h80000003_80000002_80000001_80000000;
        expWide[1] = 128'h80000007_80000006_80000005_80000004;

        sIf.tvalid = 0; sIf.tdata = '0; sIf.tkeep = '0; sIf.tstrb = '0;
        sIf.tuser  = '0; sIf.tlast = 0; sIf.tid = '0; sIf.tdest = '0;
        mIf.tready = 0;
        s1If.tvalid = 0; s1If.tdata = '0; s1If.tkeep = '0; s1If.tstrb = '0;
        s1If.tuser  = '0; s1If.tlast = 0; s1If.tid = '0; s1If.tdest = '0;
        m1If.tready = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset m_tvalid", 128'(mIf.tvalid), 128'(0));
        checkOutput("reset m_tdata",  mIf.tdata, 128'h0);
        checkOutput("reset m_tkeep",  128'(mIf.tkeep), 128'(0));
        checkOutput("reset m_tlast",  128'(mIf.tlast), 128'(0));
        checkOutput("reset m_tid",    128'(mIf.tid), 128'(0));
        checkOutput("reset s_tready", 128'(sIf.tready), 128'(1));
        checkOutput("reset r1 m_tvalid", 128'(m1If.tvalid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] running main vector table");
        for (int i = 0; i < MAIN_VECS; i++) begin
            runVector(i);
        end

        // Two lanes are now packed; an async reset must drop them at once.
        $display("[TB] reset with a partial beat");
        @(negedge clk);
        sIf.tvalid = 0;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset m_tvalid", 128'(mIf.tvalid), 128'(0));
        checkOutput("midreset m_tdata",  mIf.tdata, 128'h0);
        checkOutput("midreset m_tkeep",  128'(mIf.tkeep), 128'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = MAIN_VECS; i < vecs.size(); i++) begin
            runVector(i);
        end

        // Eight back-to-back beats with the sink stalled for three cycles.
        $display("[TB] continuous stream with output stall");
        ptr = 0;
        outCnt = 0;
        stallLeft = 3;
        for (int cyc = 0; cyc < 60 && outCnt < 2; cyc++) begin
            @(negedge clk);
            sIf.tvalid = (ptr < 8);
            sIf.tdata  = 32'h80000000 + 32'(ptr);
            sIf.tkeep  = 4'hF;
            sIf.tstrb  = 4'hF;
            sIf.tuser  = '0;
            sIf.tlast  = (ptr == 7);
            sIf.tid    = 2'd1;
            sIf.tdest  = '0;
            if (mIf.tvalid && stallLeft > 0) begin
                mIf.tready = 1'b0;
                stallLeft--;
            end else begin
                mIf.tready = 1'b1;
            end
            #1;
            if (!mIf.tready) begin
                checkOutput($sformatf("stall c%0d s_tready", cyc), 128'(sIf.tready), 128'(0));
            end
            if (mIf.tvalid && mIf.tready) begin
                checkOutput($sformatf("stall wide%0d tdata", outCnt), mIf.tdata, expWide[outCnt]);
                checkOutput($sformatf("stall wide%0d tlast", outCnt), 128'(mIf.tlast), 128'(outCnt == 1));
                outCnt++;
            end
            accepted = sIf.tvalid && sIf.tready;
            stalled  = mIf.tvalid && !mIf.tready;
            heldData = mIf.tdata;
            @(posedge clk);
            #1;
            if (accepted) ptr++;
            if (stalled) begin
                checkOutput($sformatf("stall c%0d held tvalid", cyc), 128'(mIf.tvalid), 128'(1));
                checkOutput($sformatf("stall c%0d held tdata", cyc), mIf.tdata, heldData);
            end
        end
        checkOutput("stall wide beat count", 128'(outCnt), 128'(2));
        checkOutput("stall input beats consumed", 128'(ptr), 128'(8));
        @(negedge clk);
        sIf.tvalid = 0;

        // RATIO=1 pass-through under random valid/ready.
        $display("[TB] RATIO=1 random pass-through");
        sent = 0;
        got = 0;
        pending = 0;
        curBeat = '0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            @(negedge clk);
            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                pending = 1'b1;
                curBeat = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom)};
            end
            s1If.tvalid = pending;
            s1If.tlast  = curBeat[36];
            s1If.tkeep  = curBeat[35:32];
            s1If.tstrb  = curBeat[35:32];
            s1If.tdata  = curBeat[31:0];
            m1If.tready = 1'($urandom_range(0, 1));
            #1;
            acc1 = s1If.tvalid && s1If.tready;
            if (m1If.tvalid && m1If.tready) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("r1 unexpected output beat", 128'(1), 128'(0));
                end else begin
                    expBeat = sbQueue.pop_front();
                    checkOutput($sformatf("r1 beat%0d", got),
                                128'({m1If.tlast, m1If.tkeep, m1If.tdata}), 128'(expBeat));
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (acc1) begin
                sbQueue.push_back(curBeat);
                sent++;
                pending = 1'b0;
                checkOutput($sformatf("r1 latency beat%0d", sent - 1),
                            128'({m1If.tvalid, m1If.tdata}), 128'({1'b1, curBeat[31:0]}));
            end
        end
        checkOutput("r1 beats delivered", 128'(got), 128'(1000));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
